// File: rtl/pattern_fill_writer.sv
// Sequential pattern filler: one word per address 0..DEPTH-1, address 0 presented the cycle after start.
// A word is held until wr_ready accepts it; done pulses once after the last accepted word.
module pattern_fill_writer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 24000,
  parameter int STRIPE    = 50,
  parameter int ROW_WORDS = 160
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] color_a,
  input  logic [DATA_W-1:0] color_b,
  input  logic              wr_ready,
  output logic              load,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (STRIPE > 1) ? $clog2(STRIPE) : 1;
  localparam int RW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE_S} state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] color_a_q;
  logic [DATA_W-1:0] color_b_q;

  // Running counters describing the word currently presented: index, position
  // within the 1-D stripe, column, and checker cell position/parity per axis.
  logic [IW-1:0] idx;
  logic [SW-1:0] stripe_pos;
  logic [RW-1:0] col;
  logic [SW-1:0] col_sub;
  logic          col_par;
  logic [SW-1:0] row_sub;
  logic          row_par;

  logic [IW-1:0] idx_n;
  logic [SW-1:0] stripe_pos_n;
  logic [RW-1:0] col_n;
  logic [SW-1:0] col_sub_n;
  logic          col_par_n;
  logic [SW-1:0] row_sub_n;
  logic          row_par_n;
  logic          last_word;

  assign last_word = (idx == IW'(DEPTH - 1));

  always_comb begin
    idx_n        = idx + IW'(1);
    stripe_pos_n = (stripe_pos == SW'(STRIPE - 1)) ? '0 : stripe_pos + SW'(1);
    col_n        = col + RW'(1);
    col_sub_n    = col_sub;
    col_par_n    = col_par;
    row_sub_n    = row_sub;
    row_par_n    = row_par;
    if (col == RW'(ROW_WORDS - 1)) begin
      // End of row: column state restarts, row advances within its cell.
      col_n     = '0;
      col_sub_n = '0;
      col_par_n = 1'b0;
      if (row_sub == SW'(STRIPE - 1)) begin
        row_sub_n = '0;
        row_par_n = ~row_par;
      end else begin
        row_sub_n = row_sub + SW'(1);
      end
    end else if (col_sub == SW'(STRIPE - 1)) begin
      col_sub_n = '0;
      col_par_n = ~col_par;
    end else begin
      col_sub_n = col_sub + SW'(1);
    end
  end

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] ca,
    input logic [DATA_W-1:0] cb,
    input logic [IW-1:0]     a,
    input logic              on_stripe,
    input logic              cell_odd
  );
    case (m)
      2'd0:    return ca;
      2'd1:    return on_stripe ? cb : ca;
      2'd2:    return cell_odd ? cb : ca;
      default: return DATA_W'(a);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load       <= 1'b0;
      address    <= '0;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_q     <= '0;
      color_a_q  <= '0;
      color_b_q  <= '0;
      idx        <= '0;
      stripe_pos <= '0;
      col        <= '0;
      col_sub    <= '0;
      col_par    <= 1'b0;
      row_sub    <= '0;
      row_par    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q     <= mode;
            color_a_q  <= color_a;
            color_b_q  <= color_b;
            idx        <= '0;
            stripe_pos <= '0;
            col        <= '0;
            col_sub    <= '0;
            col_par    <= 1'b0;
            row_sub    <= '0;
            row_par    <= 1'b0;
            address    <= '0;
            load       <= 1'b1;
            busy       <= 1'b1;
            out        <= pattern(mode, color_a, color_b, '0, 1'b1, 1'b0);
            state      <= FILL;
          end
        end
        FILL: begin
          if (load && wr_ready) begin
            if (last_word) begin
              load  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE_S;
            end else begin
              idx        <= idx_n;
              stripe_pos <= stripe_pos_n;
              col        <= col_n;
              col_sub    <= col_sub_n;
              col_par    <= col_par_n;
              row_sub    <= row_sub_n;
              row_par    <= row_par_n;
              address    <= ADDR_W'(idx_n);
              out        <= pattern(mode_q, color_a_q, color_b_q, idx_n,
                                    stripe_pos_n == '0, row_par_n ^ col_par_n);
            end
          end
        end
        DONE_S: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_fill_writer.sv
// Directed and randomized fills on four differently parameterised instances,
// checked against an arithmetic reference of the pattern rules.
module tb_pattern_fill_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] color_a;
  logic [15:0] color_b;
  logic        wr_ready;

  logic        ld [4];
  logic [15:0] ad [4];
  logic [15:0] dq [3];
  logic [7:0]  out3;
  logic        bz [4];
  logic        dn [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_fill_writer #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .STRIPE(3), .ROW_WORDS(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .color_a(color_a), .color_b(color_b),
    .wr_ready(wr_ready), .load(ld[0]), .address(ad[0]), .out(dq[0]), .busy(bz[0]), .done(dn[0]));

  pattern_fill_writer #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .STRIPE(2), .ROW_WORDS(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .color_a(color_a), .color_b(color_b),
    .wr_ready(wr_ready), .load(ld[1]), .address(ad[1]), .out(dq[1]), .busy(bz[1]), .done(dn[1]));

  pattern_fill_writer #(.DATA_W(16), .ADDR_W(16), .DEPTH(1), .STRIPE(50), .ROW_WORDS(160)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .color_a(color_a), .color_b(color_b),
    .wr_ready(wr_ready), .load(ld[2]), .address(ad[2]), .out(dq[2]), .busy(bz[2]), .done(dn[2]));

  pattern_fill_writer #(.DATA_W(8), .ADDR_W(16), .DEPTH(300), .STRIPE(4), .ROW_WORDS(17)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .color_a(color_a[7:0]),
    .color_b(color_b[7:0]), .wr_ready(wr_ready), .load(ld[3]), .address(ad[3]), .out(out3),
    .busy(bz[3]), .done(dn[3]));

  function automatic logic [15:0] get_out(input int d);
    if (d == 3) return {8'h00, out3};
    return dq[d];
  endfunction

  // Pattern rules straight from division/modulo of the word address.
  function automatic logic [15:0] ref_pat(input int m, input logic [15:0] ca, input logic [15:0] cb,
                                          input int a, input int stripe, input int rw, input int dw);
    int row;
    int col;
    logic [15:0] r;
    logic [15:0] mask;
    row = a / rw;
    col = a % rw;
    case (m)
      0:       r = ca;
      1:       r = (a % stripe == 0) ? cb : ca;
      2:       r = (((row / stripe) + (col / stripe)) % 2 == 1) ? cb : ca;
      default: r = a[15:0];
    endcase
    mask = (dw >= 16) ? 16'hFFFF : 16'((32'd1 << dw) - 1);
    return r & mask;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_fill(input int d, input int depth, input int stripe, input int rw, input int dw,
                          input logic [1:0] m, input logic [15:0] ca, input logic [15:0] cb,
                          input int stall_pct, input int stall_at, input int stall_n,
                          input logic hold_start, input int rst_at, input int exp_lat);
    int e;
    int cyc;
    int stalled;
    int waited;
    waited = 0;
    @(negedge clk);
    while ((bz[d] || dn[d]) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) begin
      checks++;
      errors++;
      $error("FAIL idle_timeout dut=%0d observed=busy expected=idle", d);
      return;
    end
    start = 1'b1; mode = m; color_a = ca; color_b = cb; wr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = hold_start;
    e = 0; cyc = 0; stalled = 0;
    while (e < depth) begin
      chk("load", 32'(ld[d]), 32'd1);
      chk("busy", 32'(bz[d]), 32'd1);
      chk("done_early", 32'(dn[d]), 32'd0);
      chk("addr", 32'(ad[d]), 32'(e));
      chk("data", 32'(get_out(d)), 32'(ref_pat(int'(m), ca, cb, e, stripe, rw, dw)));
      if (e == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_load", 32'(ld[d]), 32'd0);
        chk("rst_addr", 32'(ad[d]), 32'd0);
        chk("rst_out", 32'(get_out(d)), 32'd0);
        chk("rst_busy", 32'(bz[d]), 32'd0);
        chk("rst_done", 32'(dn[d]), 32'd0);
        for (int i = 0; i < 3 * depth; i++) begin
          @(negedge clk);
          chk("rst_no_done", 32'(dn[d]), 32'd0);
          chk("rst_no_load", 32'(ld[d]), 32'd0);
        end
        return;
      end
      if (e == stall_at && stalled < stall_n) begin
        wr_ready = 1'b0;
        stalled++;
      end else begin
        wr_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      end
      if (cyc > depth * 8 + 40) begin
        checks++;
        errors++;
        $error("FAIL fill_timeout dut=%0d observed=addr%0d expected=done", d, e);
        return;
      end
      @(posedge clk);
      cyc++;
      if (wr_ready) e++;
      @(negedge clk);
    end
    wr_ready = 1'b1;
    chk("done", 32'(dn[d]), 32'd1);
    chk("busy_at_done", 32'(bz[d]), 32'd0);
    chk("load_at_done", 32'(ld[d]), 32'd0);
    if (exp_lat >= 0) chk("latency", 32'(cyc), 32'(exp_lat));
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(dn[d]), 32'd0);
    chk("busy_after", 32'(bz[d]), 32'd0);
    @(negedge clk);
    chk("idle_load", 32'(ld[d]), 32'd0);
    chk("idle_busy", 32'(bz[d]), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; color_a = '0; color_b = '0; wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("reset_load", 32'(ld[d]), 32'd0);
      chk("reset_addr", 32'(ad[d]), 32'd0);
      chk("reset_out", 32'(get_out(d)), 32'd0);
      chk("reset_busy", 32'(bz[d]), 32'd0);
      chk("reset_done", 32'(dn[d]), 32'd0);
    end
    reset = 1'b0;

    // Stripe, checker, ramp with stall at address 2.
    run_fill(0, 8, 3, 4, 16, 2'd1, 16'h0000, 16'hFFFF, 0, -1, 0, 1'b0, -1, 8);
    run_fill(1, 8, 2, 4, 16, 2'd2, 16'h1111, 16'h2222, 0, -1, 0, 1'b0, -1, 8);
    run_fill(0, 8, 3, 4, 16, 2'd3, 16'h0000, 16'h0000, 0, 2, 3, 1'b0, -1, 11);
    // start held through FILL and DONE is ignored, then a fresh solid fill.
    run_fill(0, 8, 3, 4, 16, 2'd1, 16'h5555, 16'hAAAA, 0, -1, 0, 1'b1, -1, 8);
    run_fill(0, 8, 3, 4, 16, 2'd0, 16'hABCD, 16'h0F0F, 0, -1, 0, 1'b0, -1, 8);
    // Reset at address 4, then a full fresh fill.
    run_fill(0, 8, 3, 4, 16, 2'd3, 16'h1234, 16'h4321, 0, -1, 0, 1'b0, 4, -1);
    run_fill(0, 8, 3, 4, 16, 2'd2, 16'h00F0, 16'h0F00, 0, -1, 0, 1'b0, -1, 8);
    // Single-word fill.
    run_fill(2, 1, 50, 160, 16, 2'd1, 16'h1234, 16'h5678, 0, -1, 0, 1'b0, -1, 1);

    for (int n = 0; n < 6; n++) begin
      run_fill(3, 300, 4, 17, 8, 2'($urandom_range(3)), 16'($urandom), 16'($urandom),
               25, -1, 0, 1'b0, -1, -1);
    end
    for (int n = 0; n < 6; n++) begin
      run_fill(0, 8, 3, 4, 16, 2'($urandom_range(3)), 16'($urandom), 16'($urandom),
               40, -1, 0, 1'b0, -1, -1);
    end
    run_fill(3, 300, 4, 17, 8, 2'd3, 16'h0000, 16'h0000, 0, -1, 0, 1'b0, -1, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_fill_writer.md
Name: pattern_fill_writer

Overview:
Parametrised successor to the single-shot stripe frame-buffer filler. On a start request, the block walks a write port sequentially over DEPTH word addresses and presents one generated pattern word per address. It supports four selectable patterns and two programmable colours, and honours sink backpressure. It sits between the control/sequencer logic and a frame-buffer RAM write port, and signals busy/done to the controller.

Parameters:
DATA_W, 16, width of pattern word (out, color_a, color_b)
ADDR_W, 16, width of address output
DEPTH, 24000, number of words written per fill (1..2^ADDR_W)
STRIPE, 50, stripe period / checker cell size in words (>=1)
ROW_WORDS, 160, words per frame row, used by checkerboard mode (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  fill request, sampled only in IDLE
mode  in  2  pattern select: 0 solid, 1 stripe, 2 checker, 3 ramp; latched on accepted start
color_a  in  DATA_W  background colour, latched on accepted start
color_b  in  DATA_W  foreground colour, latched on accepted start
wr_ready  in  1  sink accepts the word presented this cycle
load  out  1  write valid (write enable to RAM)
address  out  ADDR_W  write address
out  out  DATA_W  write data
busy  out  1  fill in progress
done  out  1  one-cycle pulse when the last word has been accepted

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, load=0, address=0, out=0, busy=0, done=0. Reset takes priority over everything, including mid-fill. A reset mid-fill aborts the fill with no done pulse; latched mode and colours are don't-care afterwards.
- FSM states:
  - IDLE: load=0, busy=0. When start=1, latch mode/colour_a/colour_b, set address=0, load=1, busy=1, out=pattern(0), and go to FILL.
  - FILL: a transfer occurs on a cycle with load&wr_ready.
    - Transfer at address==DEPTH-1: load=0, busy=0, done=1, go to DONE.
    - Transfer otherwise: address+1, out=pattern(address+1).
    - No transfer (wr_ready=0): address, out and load hold exactly.
  - DONE: done=0 next cycle, return to IDLE. start is ignored in DONE and FILL (no queuing).
- Pattern(a) is a function of word address a. Let row=a/ROW_WORDS, col=a%ROW_WORDS.
  - mode 0: color_a.
  - mode 1: (a%STRIPE==0) ? color_b : color_a.
  - mode 2: (((row/STRIPE)+(col/STRIPE))&1) ? color_b : color_a.
  - mode 3: a, zero-extended or truncated to DATA_W.
- Implement the pattern with running row/col/stripe counters that advance on each transfer. Combinational dividers are not permitted. The counters reset to 0 on an accepted start.
- Latency: start sampled at edge k gives address 0 valid after edge k. With wr_ready held at 1, address i is presented after edge k+i, and done is high for the single cycle after edge k+DEPTH.
- DEPTH=1: a single transfer, then done.
- Address never exceeds DEPTH-1 and never wraps within a fill.
- Arithmetic uses internal counters wide enough for DEPTH, independent of ADDR_W.

Test Plan:
1. DEPTH=8, STRIPE=3, mode 1, a=0000, b=FFFF, wr_ready=1 -> out sequence FFFF,0,0,FFFF,0,0,FFFF,0 at addresses 0..7. done is high exactly 8 cycles after start is sampled. busy falls in the same cycle done rises.
2. DEPTH=8, ROW_WORDS=4, STRIPE=2, mode 2, a=1111, b=2222 -> 1111,1111,2222,2222,1111,1111,2222,2222.
3. mode 3 ramp with wr_ready low for 3 cycles while address=2 -> address=2, out=0002 and load=1 are held for 3 cycles. Sequence then resumes 3..7, and done arrives 11 cycles after start.
4. Assert start again during FILL and during DONE -> ignored: address sequence is unaffected and there is no second fill. A new start in IDLE with mode 0, a=ABCD -> all 8 words read ABCD.
5. Assert reset at address 4 mid-fill -> next cycle load=0, address=0, out=0, busy=0, done=0, with no done pulse ever. A following start runs a full fresh fill from address 0.
6. DEPTH=1, mode 1 -> exactly one transfer at address 0 with out=color_b, then done is high for 1 cycle.
